// File: rtl/mash_1n_if.sv
// Stream handshake bundle for the MASH modulator: sample input channel and
// signed DAC-code output channel, both valid/ready.
interface mash_1n_if #(
  parameter int WIDTH  = 16,
  parameter int DAC_BW = 3
);
  logic [WIDTH-1:0]  s_axis_data_tdata;
  logic              s_axis_data_tvalid;
  logic              s_axis_data_tready;
  logic [DAC_BW-1:0] m_axis_data_tdata;
  logic              m_axis_data_tvalid;
  logic              m_axis_data_tready;

  // Source/sink side: drives samples, consumes DAC codes
  modport master (
    output s_axis_data_tdata,
    output s_axis_data_tvalid,
    input  s_axis_data_tready,
    input  m_axis_data_tdata,
    input  m_axis_data_tvalid,
    output m_axis_data_tready
  );

  // Modulator side
  modport slave (
    input  s_axis_data_tdata,
    input  s_axis_data_tvalid,
    output s_axis_data_tready,
    output m_axis_data_tdata,
    output m_axis_data_tvalid,
    input  m_axis_data_tready
  );
endinterface

// File: rtl/mash_1n.sv
// MASH 1-1-..-1 sigma-delta modulator: ORDER cascaded first-order accumulators,
// carries recombined through (1-z^-1)^k noise-shaping differentiators into a
// signed DAC code. Optional LFSR dither on the first stage; one-deep output
// register with valid/ready backpressure.
module mash_1n #(
  parameter int          WIDTH     = 16,
  parameter int          ORDER     = 2,
  parameter int          DAC_BW    = 3,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic   aclk,
  input  logic   rst,
  input  logic   dither_enable,
  input  logic   soft_clr,
  mash_1n_if.slave bus
);

  if (ORDER < 1 || ORDER > 4 || DAC_BW < ORDER + 1) begin : g_bad_params
    $error("mash_1n: ORDER must be 1..4 and DAC_BW >= ORDER+1");
  end
  if (LFSR_SEED == 16'h0000) begin : g_bad_seed
    $error("mash_1n: LFSR_SEED must be nonzero");
  end

  logic [WIDTH-1:0]  acc_nxt [ORDER];
  logic [ORDER-1:0]  carry;
  logic signed [5:0] part [ORDER+1];
  logic [15:0]       lfsr;
  logic              dith;
  logic              accept;
  logic              stall_clr;
  logic [DAC_BW-1:0] m_tdata_q;
  logic              m_tvalid_q;

  function automatic logic signed [5:0] sx(input logic b);
    return {5'b00000, b};
  endfunction

  assign bus.s_axis_data_tready = !rst && !soft_clr &&
                                  (!m_tvalid_q || bus.m_axis_data_tready);
  assign accept    = bus.s_axis_data_tvalid && bus.s_axis_data_tready;
  assign stall_clr = rst || soft_clr;
  assign dith      = dither_enable & lfsr[0];
  assign part[0]   = '0;

  for (genvar s = 0; s < ORDER; s++) begin : g_stage
    logic [WIDTH-1:0]  acc;
    logic [WIDTH:0]    sum;
    logic signed [5:0] term;

    // Accumulators ripple combinationally: stage s adds the freshly updated
    // value of stage s-1 within the same accepted sample.
    if (s == 0) begin : g_first
      assign sum = {1'b0, acc} + {1'b0, bus.s_axis_data_tdata} + {{WIDTH{1'b0}}, dith};
    end else begin : g_cascade
      assign sum = {1'b0, acc} + {1'b0, acc_nxt[s-1]};
    end
    assign acc_nxt[s] = sum[WIDTH-1:0];
    assign carry[s]   = sum[WIDTH];

    // Accumulator register, wraps modulo 2^WIDTH
    always_ff @(posedge aclk) begin
      if (stall_clr)   acc <= '0;
      else if (accept) acc <= acc_nxt[s];
    end

    // Stage s carry passes through s differentiators; coefficients are the
    // binomial expansion of (1-z^-1)^s over the last s carries.
    if (s == 0) begin : g_d0
      assign term = sx(carry[s]);
    end else if (s == 1) begin : g_d1
      logic h;
      // Carry history, one sample deep
      always_ff @(posedge aclk) begin
        if (stall_clr)   h <= 1'b0;
        else if (accept) h <= carry[s];
      end
      assign term = sx(carry[s]) - sx(h);
    end else if (s == 2) begin : g_d2
      logic [1:0] h;
      // Carry history, two samples deep
      always_ff @(posedge aclk) begin
        if (stall_clr)   h <= '0;
        else if (accept) h <= {h[0], carry[s]};
      end
      assign term = sx(carry[s]) - 6'sd2 * sx(h[0]) + sx(h[1]);
    end else begin : g_d3
      logic [2:0] h;
      // Carry history, three samples deep
      always_ff @(posedge aclk) begin
        if (stall_clr)   h <= '0;
        else if (accept) h <= {h[1:0], carry[s]};
      end
      assign term = sx(carry[s]) - 6'sd3 * sx(h[0]) + 6'sd3 * sx(h[1]) - sx(h[2]);
    end

    assign part[s+1] = part[s] + term;
  end

  // Dither LFSR, x^16+x^14+x^13+x^11+1, steps once per accepted sample
  always_ff @(posedge aclk) begin
    if (rst)         lfsr <= LFSR_SEED;
    else if (accept) lfsr <= {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
  end

  // Output register: load on accept, drop valid once consumed, hold otherwise
  always_ff @(posedge aclk) begin
    if (rst) begin
      m_tdata_q  <= '0;
      m_tvalid_q <= 1'b0;
    end else if (accept) begin
      m_tdata_q  <= DAC_BW'(part[ORDER]);
      m_tvalid_q <= 1'b1;
    end else if (m_tvalid_q && bus.m_axis_data_tready) begin
      m_tvalid_q <= 1'b0;
    end
  end

  assign bus.m_axis_data_tdata  = m_tdata_q;
  assign bus.m_axis_data_tvalid = m_tvalid_q;

endmodule

// File: tb/tb_mash_1n.sv
// Bench for mash_1n: four instances (ORDER 1..4) share one stimulus stream and
// are scored every cycle against an arithmetic MASH model; fixed vectors and
// hand sequences cover handshake, soft clear and reset corner cases.
module tb_mash_1n;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        dith = 1'b0;
  logic        sclr = 1'b0;
  logic        s_valid = 1'b0;
  logic        m_rdy = 1'b1;
  logic [15:0] x = '0;
  logic        last_rdy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mash_1n_if #(.WIDTH(16), .DAC_BW(3)) bus1 ();
  mash_1n_if #(.WIDTH(16), .DAC_BW(3)) bus2 ();
  mash_1n_if #(.WIDTH(16), .DAC_BW(4)) bus3 ();
  mash_1n_if #(.WIDTH(16), .DAC_BW(5)) bus4 ();

  assign bus1.s_axis_data_tdata = x;  assign bus1.s_axis_data_tvalid = s_valid;  assign bus1.m_axis_data_tready = m_rdy;
  assign bus2.s_axis_data_tdata = x;  assign bus2.s_axis_data_tvalid = s_valid;  assign bus2.m_axis_data_tready = m_rdy;
  assign bus3.s_axis_data_tdata = x;  assign bus3.s_axis_data_tvalid = s_valid;  assign bus3.m_axis_data_tready = m_rdy;
  assign bus4.s_axis_data_tdata = x;  assign bus4.s_axis_data_tvalid = s_valid;  assign bus4.m_axis_data_tready = m_rdy;

  mash_1n #(.WIDTH(16), .ORDER(1), .DAC_BW(3)) u1 (.aclk(clk), .rst(rst), .dither_enable(dith), .soft_clr(sclr), .bus(bus1));
  mash_1n #(.WIDTH(16), .ORDER(2), .DAC_BW(3)) u2 (.aclk(clk), .rst(rst), .dither_enable(dith), .soft_clr(sclr), .bus(bus2));
  mash_1n #(.WIDTH(16), .ORDER(3), .DAC_BW(4)) u3 (.aclk(clk), .rst(rst), .dither_enable(dith), .soft_clr(sclr), .bus(bus3));
  mash_1n #(.WIDTH(16), .ORDER(4), .DAC_BW(5)) u4 (.aclk(clk), .rst(rst), .dither_enable(dith), .soft_clr(sclr), .bus(bus4));

  function automatic int get_y(input int o);
    case (o)
      1:       return int'($signed(bus1.m_axis_data_tdata));
      2:       return int'($signed(bus2.m_axis_data_tdata));
      3:       return int'($signed(bus3.m_axis_data_tdata));
      default: return int'($signed(bus4.m_axis_data_tdata));
    endcase
  endfunction

  function automatic int get_v(input int o);
    case (o)
      1:       return int'(bus1.m_axis_data_tvalid);
      2:       return int'(bus2.m_axis_data_tvalid);
      3:       return int'(bus3.m_axis_data_tvalid);
      default: return int'(bus4.m_axis_data_tvalid);
    endcase
  endfunction

  function automatic int get_r(input int o);
    case (o)
      1:       return int'(bus1.s_axis_data_tready);
      2:       return int'(bus2.s_axis_data_tready);
      3:       return int'(bus3.s_axis_data_tready);
      default: return int'(bus4.s_axis_data_tready);
    endcase
  endfunction

  task automatic chk(input string name, input int idx, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s [%0d]: got %0d expected %0d", name, idx, act, exp);
    end
  endtask

  task automatic chk_within(input string name, input int act, input int lo, input int hi);
    checks++;
    if (act < lo || act > hi) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  // ---------------- reference model ----------------
  int unsigned macc [1:4][0:3];
  int          mch  [1:4][0:3][0:3];  // carry of stage s, j samples ago
  logic [15:0] mlfsr = 16'hACE1;
  bit          mtv = 1'b0;
  int          my [1:4] = '{0, 0, 0, 0};

  task automatic model_clear();
    for (int o = 1; o <= 4; o++)
      for (int s = 0; s < 4; s++) begin
        macc[o][s] = 0;
        for (int j = 0; j < 4; j++) mch[o][s][j] = 0;
      end
  endtask

  task automatic model_reset();
    model_clear();
    mlfsr = 16'hACE1;
    mtv   = 1'b0;
    for (int o = 1; o <= 4; o++) my[o] = 0;
  endtask

  task automatic model_accept();
    int unsigned inp, sum, d;
    int v [4];
    int y;
    d = (dith && mlfsr[0]) ? 1 : 0;
    for (int o = 1; o <= 4; o++) begin
      inp = int'(x) + d;
      y = 0;
      for (int s = 0; s < o; s++) begin
        sum = macc[o][s] + inp;
        macc[o][s] = sum % 65536;
        for (int j = 3; j > 0; j--) mch[o][s][j] = mch[o][s][j-1];
        mch[o][s][0] = int'(sum / 65536);
        inp = macc[o][s];
      end
      // take the s-th backward difference of each stage's carry stream
      for (int s = 0; s < o; s++) begin
        for (int j = 0; j < 4; j++) v[j] = mch[o][s][j];
        for (int n = 0; n < s; n++)
          for (int j = 0; j < 3; j++) v[j] = v[j] - v[j+1];
        y += v[0];
      end
      my[o] = y;
    end
    mlfsr = {mlfsr[0] ^ mlfsr[2] ^ mlfsr[3] ^ mlfsr[5], mlfsr[15:1]};
    mtv = 1'b1;
  endtask

  // One clock: check ready, advance model and DUTs, score all outputs
  task automatic cycle();
    bit exp_r, acc;
    #1;
    exp_r = !rst && !sclr && (!mtv || m_rdy);
    for (int o = 1; o <= 4; o++) chk("s_tready", o, get_r(o), int'(exp_r));
    last_rdy = bus2.s_axis_data_tready;
    acc = s_valid && exp_r;
    @(posedge clk);
    #1;
    if (rst) model_reset();
    else if (sclr) begin
      model_clear();
      if (mtv && m_rdy) mtv = 1'b0;
    end else if (acc) model_accept();
    else if (mtv && m_rdy) mtv = 1'b0;
    for (int o = 1; o <= 4; o++) begin
      chk("m_tvalid", o, get_v(o), int'(mtv));
      chk("m_tdata", o, get_y(o), my[o]);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; s_valid = 1'b0; sclr = 1'b0; m_rdy = 1'b1;
    cycle();
    rst = 1'b0;
  endtask

  typedef struct {
    logic vld; logic rdy; logic clr;
    int   e_r; int e_v; int e_y;
  } vec_t;

  initial begin
    vec_t tbl [26];
    int   nz, oor, sum, y;
    int   first [64];

    // ORDER=2, x=0x8000: 0,1,1,0 pattern, 5-cycle stall, soft clears, idle gap
    tbl[0]  = '{1, 1, 0, 1, 1, 0};
    tbl[1]  = '{1, 1, 0, 1, 1, 1};
    for (int i = 2; i <= 6; i++) tbl[i] = '{1, 0, 0, 0, 1, 1};
    tbl[7]  = '{1, 1, 0, 1, 1, 1};
    tbl[8]  = '{1, 1, 0, 1, 1, 0};
    tbl[9]  = '{1, 1, 0, 1, 1, 0};
    tbl[10] = '{1, 1, 0, 1, 1, 1};
    tbl[11] = '{1, 1, 1, 0, 0, 1};
    tbl[12] = '{1, 1, 0, 1, 1, 0};
    tbl[13] = '{1, 1, 0, 1, 1, 1};
    tbl[14] = '{1, 1, 0, 1, 1, 1};
    tbl[15] = '{1, 1, 0, 1, 1, 0};
    tbl[16] = '{1, 1, 0, 1, 1, 0};
    tbl[17] = '{1, 1, 0, 1, 1, 1};
    tbl[18] = '{1, 0, 1, 0, 1, 1};
    tbl[19] = '{1, 1, 0, 1, 1, 0};
    tbl[20] = '{1, 1, 0, 1, 1, 1};
    tbl[21] = '{1, 1, 0, 1, 1, 1};
    tbl[22] = '{1, 1, 0, 1, 1, 0};
    tbl[23] = '{0, 1, 0, 1, 0, 0};
    tbl[24] = '{1, 1, 0, 1, 1, 0};
    tbl[25] = '{1, 1, 0, 1, 1, 1};

    rst = 1'b1;
    cycle();
    cycle();
    chk("reset_tvalid", 0, get_v(2), 0);
    chk("reset_tdata", 0, get_y(2), 0);
    rst = 1'b0;

    x = 16'h8000;
    for (int i = 0; i < 26; i++) begin
      s_valid = tbl[i].vld; m_rdy = tbl[i].rdy; sclr = tbl[i].clr;
      cycle();
      chk("tbl_s_tready", i, int'(last_rdy), tbl[i].e_r);
      chk("tbl_m_tvalid", i, get_v(2), tbl[i].e_v);
      chk("tbl_m_tdata", i, get_y(2), tbl[i].e_y);
    end

    // ORDER=1, x=0x4000: 0,0,0,1 repeating
    do_reset();
    x = 16'h4000; s_valid = 1'b1; m_rdy = 1'b1;
    for (int i = 0; i < 8; i++) begin
      cycle();
      chk("o1_seq", i, get_y(1), (i % 4 == 3) ? 1 : 0);
    end

    // ORDER=4, x=0 for 1000 samples: all zero
    do_reset();
    x = 16'h0000; s_valid = 1'b1; nz = 0;
    for (int i = 0; i < 1000; i++) begin
      cycle();
      if (get_y(4) != 0) nz++;
    end
    chk("o4_zero_input", 0, nz, 0);

    // Random traffic, backpressure, soft clears, dither, occasional reset
    do_reset();
    oor = 0;
    for (int i = 0; i < 3000; i++) begin
      s_valid = ($urandom_range(0, 9) < 8);
      m_rdy   = ($urandom_range(0, 9) < 7);
      sclr    = ($urandom_range(0, 29) == 0);
      rst     = ($urandom_range(0, 299) == 0);
      dith    = $urandom_range(0, 1);
      x       = ($urandom_range(0, 9) == 0) ? 16'hFFFF : 16'($urandom);
      cycle();
      if (get_v(4) != 0) begin
        y = get_y(4);
        if (y < -7 || y > 8) oor++;
      end
    end
    chk("o4_range", 0, oor, 0);

    // ORDER=3 with dither: long-run mean, then reset mid-stream and restart
    do_reset();
    dith = 1'b1; x = 16'h1234; s_valid = 1'b1; m_rdy = 1'b1; sum = 0;
    for (int i = 0; i < 65536; i++) begin
      cycle();
      if (i < 64) first[i] = my[3];
      sum += get_y(3);
    end
    chk_within("o3_mean_sum", sum, 4660 - 65, 4660 + 65);
    rst = 1'b1;
    cycle();
    chk("midrst_tvalid", 0, get_v(3), 0);
    rst = 1'b0;
    for (int i = 0; i < 64; i++) begin
      cycle();
      chk("o3_restart", i, get_y(3), first[i]);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
